// File: rtl/fft_frame_sched.sv
// fft_frame_sched: frame-level sequencer for the mixed-radix PUSCH FFT.
// Loads one frame of write addresses, launches the radix engine once per
// pow3x5 column group, then drains pow2 natural-order output addresses.
// Optional engine watchdog: define FFT_SCHED_TIMEOUT_EN.
module fft_frame_sched #(
    parameter int ADDR_W      = 11,
    parameter int MAX_N       = 1200,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_start,
    input  logic [8:0]        i_cfg_pow2,
    input  logic [7:0]        i_cfg_pow3x5,
    input  logic              i_in_valid,
    input  logic              i_in_last,
    output logic              o_wr_en,
    output logic [ADDR_W-1:0] o_wr_addr,
    output logic              o_eng_start,
    output logic [7:0]        o_eng_group,
    input  logic              i_eng_done,
    output logic              o_out_valid,
    output logic [ADDR_W-1:0] o_out_addr,
    output logic              o_busy,
    output logic              o_frame_done,
    output logic              o_err,
    output logic [1:0]        o_err_code
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_ISSUE, S_WAIT, S_DRAIN, S_DONE
    } state_t;

    state_t            r_state, w_state_nx;
    logic [ADDR_W-1:0] r_cnt, w_cnt_nx;
    logic [ADDR_W-1:0] r_last, w_last_nx;
    logic [7:0]        r_g, w_g_nx;
    logic [8:0]        r_k, w_k_nx;
    logic [8:0]        r_pow2, w_pow2_nx;
    logic [7:0]        r_p35, w_p35_nx;

    logic              r_wr_en, w_wr_en_nx;
    logic [ADDR_W-1:0] r_wr_addr, w_wr_addr_nx;
    logic              r_eng_start, w_eng_start_nx;
    logic [7:0]        r_eng_group, w_eng_group_nx;
    logic              r_out_valid, w_out_valid_nx;
    logic [ADDR_W-1:0] r_out_addr, w_out_addr_nx;
    logic              r_busy, w_busy_nx;
    logic              r_frame_done, w_frame_done_nx;
    logic              r_err, w_err_nx;
    logic [1:0]        r_err_code, w_err_code_nx;

    // Frame length check only; drain addresses are accumulated, not multiplied.
    logic [16:0] w_prod;
    assign w_prod = {8'b0, i_cfg_pow2} * {9'b0, i_cfg_pow3x5};

`ifdef FFT_SCHED_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    logic [TO_W-1:0] r_to, w_to_nx;
`else
    localparam int unused_timeout_cyc = TIMEOUT_CYC;
`endif

    assign o_wr_en      = r_wr_en;
    assign o_wr_addr    = r_wr_addr;
    assign o_eng_start  = r_eng_start;
    assign o_eng_group  = r_eng_group;
    assign o_out_valid  = r_out_valid;
    assign o_out_addr   = r_out_addr;
    assign o_busy       = r_busy;
    assign o_frame_done = r_frame_done;
    assign o_err        = r_err;
    assign o_err_code   = r_err_code;

    // Next state, counters and next values of the registered outputs.
    always_comb begin
        w_state_nx      = r_state;
        w_cnt_nx        = r_cnt;
        w_last_nx       = r_last;
        w_g_nx          = r_g;
        w_k_nx          = r_k;
        w_pow2_nx       = r_pow2;
        w_p35_nx        = r_p35;
        w_wr_en_nx      = 1'b0;
        w_wr_addr_nx    = r_wr_addr;
        w_eng_start_nx  = 1'b0;
        w_eng_group_nx  = r_eng_group;
        w_out_valid_nx  = 1'b0;
        w_out_addr_nx   = r_out_addr;
        w_frame_done_nx = 1'b0;
        w_err_nx        = 1'b0;
        w_err_code_nx   = r_err_code;
`ifdef FFT_SCHED_TIMEOUT_EN
        w_to_nx         = r_to;
`endif
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    if (w_prod == 17'd0 || w_prod > 17'(MAX_N)) begin
                        w_err_nx      = 1'b1;
                        w_err_code_nx = 2'd1;
                    end else begin
                        w_pow2_nx  = i_cfg_pow2;
                        w_p35_nx   = i_cfg_pow3x5;
                        w_last_nx  = ADDR_W'(w_prod - 17'd1);
                        w_cnt_nx   = '0;
                        w_g_nx     = '0;
                        w_k_nx     = '0;
                        w_state_nx = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                if (i_in_valid) begin
                    // The sample is written even when it ends the frame in error.
                    w_wr_en_nx   = 1'b1;
                    w_wr_addr_nx = r_cnt;
                    w_cnt_nx     = r_cnt + ADDR_W'(1);
                    if (i_in_last && r_cnt == r_last) begin
                        w_state_nx     = S_ISSUE;
                        w_eng_start_nx = 1'b1;
                        w_eng_group_nx = r_g;
                    end else if (i_in_last || r_cnt == r_last) begin
                        w_err_nx      = 1'b1;
                        w_err_code_nx = 2'd2;
                        w_state_nx    = S_IDLE;
                    end
                end
            end
            S_ISSUE: begin
                // eng_start is high now; a coincident eng_done is ignored.
                w_state_nx = S_WAIT;
`ifdef FFT_SCHED_TIMEOUT_EN
                w_to_nx    = '0;
`endif
            end
            S_WAIT: begin
                if (i_eng_done) begin
                    w_state_nx     = S_DRAIN;
                    w_out_valid_nx = 1'b1;
                    w_out_addr_nx  = ADDR_W'(r_g);
                    w_k_nx         = '0;
                end
`ifdef FFT_SCHED_TIMEOUT_EN
                else if (r_to == TO_W'(TIMEOUT_CYC - 1)) begin
                    w_err_nx      = 1'b1;
                    w_err_code_nx = 2'd3;
                    w_state_nx    = S_IDLE;
                end else begin
                    w_to_nx = r_to + TO_W'(1);
                end
`endif
            end
            S_DRAIN: begin
                // r_k is the index of the result currently on out_addr.
                if (r_k == r_pow2 - 9'd1) begin
                    if (r_g == r_p35 - 8'd1) begin
                        w_state_nx      = S_DONE;
                        w_frame_done_nx = 1'b1;
                    end else begin
                        w_g_nx         = r_g + 8'd1;
                        w_state_nx     = S_ISSUE;
                        w_eng_start_nx = 1'b1;
                        w_eng_group_nx = r_g + 8'd1;
                    end
                end else begin
                    w_out_valid_nx = 1'b1;
                    w_out_addr_nx  = r_out_addr + ADDR_W'(r_p35);
                    w_k_nx         = r_k + 9'd1;
                end
            end
            S_DONE: begin
                w_state_nx = S_IDLE;
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
        w_busy_nx = (w_state_nx != S_IDLE);
    end

    // State, counters and output registers; reset aborts any frame silently.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_last       <= '0;
            r_g          <= '0;
            r_k          <= '0;
            r_pow2       <= '0;
            r_p35        <= '0;
            r_wr_en      <= 1'b0;
            r_wr_addr    <= '0;
            r_eng_start  <= 1'b0;
            r_eng_group  <= '0;
            r_out_valid  <= 1'b0;
            r_out_addr   <= '0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
            r_err        <= 1'b0;
            r_err_code   <= '0;
        end else begin
            r_state      <= w_state_nx;
            r_cnt        <= w_cnt_nx;
            r_last       <= w_last_nx;
            r_g          <= w_g_nx;
            r_k          <= w_k_nx;
            r_pow2       <= w_pow2_nx;
            r_p35        <= w_p35_nx;
            r_wr_en      <= w_wr_en_nx;
            r_wr_addr    <= w_wr_addr_nx;
            r_eng_start  <= w_eng_start_nx;
            r_eng_group  <= w_eng_group_nx;
            r_out_valid  <= w_out_valid_nx;
            r_out_addr   <= w_out_addr_nx;
            r_busy       <= w_busy_nx;
            r_frame_done <= w_frame_done_nx;
            r_err        <= w_err_nx;
            r_err_code   <= w_err_code_nx;
        end
    end

`ifdef FFT_SCHED_TIMEOUT_EN
    // Engine watchdog counter, cleared on entry to WAIT.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) r_to <= '0;
        else          r_to <= w_to_nx;
    end
`endif

endmodule
